// File: rtl/sdf_stage.sv
// Radix-2 single-path delay-feedback FFT stage: M-deep feedback buffer, butterfly, twiddle index.
// Optional build macro SDF_STAGE_ROUND_EN selects round-half-up scaling instead of floor.
module sdf_stage #(
  parameter int WIDTH = 16,
  parameter int N     = 64,
  parameter int M     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       di_en,
  input  logic signed [WIDTH-1:0]    di_re,
  input  logic signed [WIDTH-1:0]    di_im,
  output logic                       do_en,
  output logic signed [WIDTH-1:0]    do_re,
  output logic signed [WIDTH-1:0]    do_im,
  output logic [$clog2(N)-1:0]       tw_addr,
  output logic                       tw_en
);

  localparam int CNT_W    = $clog2(N);
  localparam int PTR_W    = (M > 1) ? $clog2(M) : 1;
  localparam int TW_SHIFT = $clog2(N / (2 * M));
  localparam logic [CNT_W-1:0] M_BIT    = CNT_W'(M);
  localparam logic [CNT_W-1:0] K_MASK   = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(M - 1);

  // Halve a WIDTH+1 bit sum/difference back to WIDTH bits.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH:0] v);
`ifdef SDF_STAGE_ROUND_EN
    // floor((v+1)/2) = floor(v/2) + lsb; only the largest positive odd value can overflow
    if (v[WIDTH:1] == {1'b0, {(WIDTH-1){1'b1}}} && v[0])
      return {1'b0, {(WIDTH-1){1'b1}}};
    return v[WIDTH:1] + WIDTH'(v[0]);
`else
    return v[WIDTH:1];
`endif
  endfunction

  logic [CNT_W-1:0] count;
  logic             drain_active;
  logic [PTR_W-1:0] drain_idx;
  logic [PTR_W-1:0] ptr;
  logic [M-1:0]     buf_vld;
  logic signed [WIDTH-1:0] buf_re [M];
  logic signed [WIDTH-1:0] buf_im [M];

  logic                    advance;
  logic                    bfly_p0;
  logic                    x_vld_p0;
  logic signed [WIDTH-1:0] x_re_p0, x_im_p0;
  logic signed [WIDTH:0]   sum_re_p0, sum_im_p0, dif_re_p0, dif_im_p0;
  logic signed [WIDTH-1:0] sum_s_re_p0, sum_s_im_p0, dif_s_re_p0, dif_s_im_p0;
  logic [CNT_W-1:0]        k_p0;
  logic [CNT_W-1:0]        tw_p0;

  // Stage 0: buffer read, butterfly, twiddle index
  assign advance  = di_en | drain_active;
  assign bfly_p0  = (count & M_BIT) != '0;
  assign x_re_p0  = buf_re[ptr];
  assign x_im_p0  = buf_im[ptr];
  assign x_vld_p0 = buf_vld[ptr];

  assign sum_re_p0 = {x_re_p0[WIDTH-1], x_re_p0} + {di_re[WIDTH-1], di_re};
  assign sum_im_p0 = {x_im_p0[WIDTH-1], x_im_p0} + {di_im[WIDTH-1], di_im};
  assign dif_re_p0 = {x_re_p0[WIDTH-1], x_re_p0} - {di_re[WIDTH-1], di_re};
  assign dif_im_p0 = {x_im_p0[WIDTH-1], x_im_p0} - {di_im[WIDTH-1], di_im};

  assign sum_s_re_p0 = scale(sum_re_p0);
  assign sum_s_im_p0 = scale(sum_im_p0);
  assign dif_s_re_p0 = scale(dif_re_p0);
  assign dif_s_im_p0 = scale(dif_im_p0);

  // While draining, the input counter has already wrapped, so the drain index tracks k
  assign k_p0  = drain_active ? CNT_W'(drain_idx) : (count & K_MASK);
  assign tw_p0 = k_p0 << TW_SHIFT;

  // Feedback buffer holds no reset; stale words are masked by buf_vld
  always_ff @(posedge clock) begin
    if (advance) begin
      buf_re[ptr] <= bfly_p0 ? dif_s_re_p0 : di_re;
      buf_im[ptr] <= bfly_p0 ? dif_s_im_p0 : di_im;
    end
  end

  // Stage 1: output registers and control state
  always_ff @(posedge clock) begin
    if (!reset) begin
      count        <= '0;
      drain_active <= 1'b0;
      drain_idx    <= '0;
      ptr          <= '0;
      buf_vld      <= '0;
      do_en        <= 1'b0;
      do_re        <= '0;
      do_im        <= '0;
      tw_en        <= 1'b0;
      tw_addr      <= '0;
    end else begin
      if (di_en) begin
        count <= count + 1'b1;
      end else if (count != '0) begin
        // Frame broken off mid-way: discard it and restart at index 0
        count <= '0;
        if (!drain_active)
          buf_vld <= '0;
      end

      if (di_en && count == CNT_LAST) begin
        drain_active <= 1'b1;
        drain_idx    <= '0;
      end else if (drain_active) begin
        drain_idx <= drain_idx + 1'b1;
        if (drain_idx == PTR_LAST)
          drain_active <= 1'b0;
      end

      if (advance) begin
        ptr          <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        buf_vld[ptr] <= bfly_p0;
      end

      do_en <= advance & (bfly_p0 | x_vld_p0);
      if (advance) begin
        do_re   <= bfly_p0 ? sum_s_re_p0 : x_re_p0;
        do_im   <= bfly_p0 ? sum_s_im_p0 : x_im_p0;
        tw_en   <= !bfly_p0 && x_vld_p0;
        tw_addr <= (!bfly_p0 && x_vld_p0) ? tw_p0 : '0;
      end else begin
        tw_en   <= 1'b0;
        tw_addr <= '0;
      end
    end
  end

endmodule
